// File: rtl/ts_serial_sync_aligner.sv
// ts_serial_sync_aligner
//   Read-side consumer of the 1-bit MPEG-TS capture FIFO. Shifts serial bits
//   in MSB first, hunts for the sync byte, confirms it over SYNC_CONFIRM
//   packet-spaced syncs, then emits byte-aligned packets with SOP/EOP on a
//   valid/ready stream. A flywheel tolerates LOSS_COUNT-1 missing syncs.
// Ports
//   clk_i, rst_ni          FIFO read clock, async active-low reset
//   fifo_q_i, fifo_empty_i show-ahead FIFO bit and empty flag
//   fifo_rdreq_o           consume fifo_q_i at this edge (combinational)
//   out_data_o/out_valid_o/out_ready_i  byte stream handshake
//   out_sop_o/out_eop_o    packet byte 0 / byte PKT_LEN-1
//   out_err_o              on SOP byte: sync was missing, position flywheeled
//   locked_o               lock state, pkt_count_o packets emitted (wraps)
module ts_serial_sync_aligner #(
  parameter int          PKT_LEN      = 188,
  parameter logic [7:0]  SYNC_BYTE    = 8'h47,
  parameter int          SYNC_CONFIRM = 2,
  parameter int          LOSS_COUNT   = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fifo_q_i,
  input  logic        fifo_empty_i,
  output logic        fifo_rdreq_o,
  output logic [7:0]  out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        out_sop_o,
  output logic        out_eop_o,
  output logic        out_err_o,
  output logic        locked_o,
  output logic [15:0] pkt_count_o
);

  localparam int IW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int CW = $clog2(SYNC_CONFIRM + 1);
  localparam int MW = $clog2(LOSS_COUNT + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(PKT_LEN - 1);
  localparam logic [IW-1:0] FIRST_PAY = IW'(1 % PKT_LEN);
  localparam logic [CW-1:0] CONF_N    = CW'(SYNC_CONFIRM);
  localparam logic [MW-1:0] LOSS_N    = MW'(LOSS_COUNT);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_e;

  state_e          state_q, state_d;
  logic [7:0]      sreg_q, sreg_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [IW-1:0]   byte_idx_q, byte_idx_d;
  logic [CW-1:0]   confirm_q, confirm_d;
  logic [MW-1:0]   miss_q, miss_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            sop_q, sop_d, eop_q, eop_d, err_q, err_d;
  logic [15:0]     pkt_cnt_q, pkt_cnt_d;

  logic            stall, rdreq, byte_done, load, ld_sop, ld_eop, ld_err;
  logic [7:0]      sreg_n;
  logic [IW-1:0]   idx_nxt;

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    confirm_d  = confirm_q;
    miss_d     = miss_q;
    data_d     = data_q;
    valid_d    = valid_q;
    sop_d      = sop_q;
    eop_d      = eop_q;
    err_d      = err_q;
    pkt_cnt_d  = pkt_cnt_q;
    load       = 1'b0;
    ld_sop     = 1'b0;
    ld_eop     = 1'b0;
    ld_err     = 1'b0;

    // Hold off only the bit that would complete a byte while the single
    // output slot is still occupied; earlier bits of the byte keep flowing.
    stall     = valid_q & ~out_ready_i & (state_q == LOCKED) & (bit_cnt_q == 3'd7);
    rdreq     = ~fifo_empty_i & ~stall;
    sreg_n    = {sreg_q[6:0], fifo_q_i};
    byte_done = (bit_cnt_q == 3'd7);
    idx_nxt   = (byte_idx_q == LAST_IDX) ? '0 : byte_idx_q + 1'b1;

    if (valid_q && out_ready_i) valid_d = 1'b0;

    if (rdreq) begin
      sreg_d = sreg_n;
      unique case (state_q)
        HUNT: begin
          if (sreg_n == SYNC_BYTE) begin
            bit_cnt_d  = '0;
            byte_idx_d = FIRST_PAY;
            confirm_d  = CW'(1);
            miss_d     = '0;
            if (SYNC_CONFIRM == 1) begin
              state_d = LOCKED;
              load    = 1'b1;
              ld_sop  = 1'b1;
            end else begin
              state_d = VERIFY;
            end
          end
        end
        VERIFY: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (byte_done) begin
            byte_idx_d = idx_nxt;
            if (byte_idx_q == '0) begin
              if (sreg_n != SYNC_BYTE) begin
                // sreg keeps the stream history so the hunt continues bitwise
                state_d = HUNT;
              end else if (confirm_q + 1'b1 == CONF_N) begin
                state_d = LOCKED;
                miss_d  = '0;
                load    = 1'b1;
                ld_sop  = 1'b1;
              end else begin
                confirm_d = confirm_q + 1'b1;
              end
            end
          end
        end
        LOCKED: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (byte_done) begin
            byte_idx_d = idx_nxt;
            if (byte_idx_q == '0) begin
              if (sreg_n == SYNC_BYTE) begin
                miss_d = '0;
                load   = 1'b1;
                ld_sop = 1'b1;
              end else if (miss_q + 1'b1 < LOSS_N) begin
                // flywheel: trust the packet timing, flag the missing sync
                miss_d = miss_q + 1'b1;
                load   = 1'b1;
                ld_sop = 1'b1;
                ld_err = 1'b1;
              end else begin
                state_d = HUNT;
                miss_d  = '0;
              end
            end else begin
              load   = 1'b1;
              ld_eop = (byte_idx_q == LAST_IDX);
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (load) begin
      valid_d = 1'b1;
      data_d  = sreg_n;
      sop_d   = ld_sop;
      eop_d   = ld_eop;
      err_d   = ld_err;
      if (ld_eop) pkt_cnt_d = pkt_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= HUNT;
      sreg_q     <= '0;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      confirm_q  <= '0;
      miss_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      err_q      <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      confirm_q  <= confirm_d;
      miss_q     <= miss_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      err_q      <= err_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign fifo_rdreq_o = rdreq;
  assign out_data_o   = data_q;
  assign out_valid_o  = valid_q;
  assign out_sop_o    = sop_q;
  assign out_eop_o    = eop_q;
  assign out_err_o    = err_q;
  assign locked_o     = (state_q == LOCKED);
  assign pkt_count_o  = pkt_cnt_q;

endmodule

// File: tb/tb_ts_serial_sync_aligner.sv
// Bench for ts_serial_sync_aligner: builds serial TS streams, predicts the
// emitted byte stream from bit positions (hunt, PKT_LEN-spaced confirmation,
// flywheel) and scoreboards every accepted byte.
module tb_ts_serial_sync_aligner;
  localparam int         PKT_LEN = 188;
  localparam logic [7:0] SYNC    = 8'h47;
  localparam int         SC      = 2;
  localparam int         LC      = 3;
  localparam int         PB      = PKT_LEN * 8;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        fifo_q = 1'b0, fifo_empty = 1'b1, out_ready = 1'b0;
  logic        fifo_rdreq, out_valid, out_sop, out_eop, out_err, locked;
  logic [7:0]  out_data;
  logic [15:0] pkt_count;

  always #5 clk = ~clk;

  ts_serial_sync_aligner dut (
    .clk_i(clk), .rst_ni(rst_n), .fifo_q_i(fifo_q), .fifo_empty_i(fifo_empty),
    .fifo_rdreq_o(fifo_rdreq), .out_data_o(out_data), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_sop_o(out_sop), .out_eop_o(out_eop),
    .out_err_o(out_err), .locked_o(locked), .pkt_count_o(pkt_count)
  );

  typedef struct packed {logic [7:0] d; logic sop; logic eop; logic err;} ob_t;

  ob_t exp_q[$];
  bit  stream[$];
  int  model_pkts = 0, model_lock_pos = -1;
  bit  model_locked = 0;
  int  n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_byte(logic [7:0] b);
    for (int i = 7; i >= 0; i--) stream.push_back(b[i]);
  endfunction

  function automatic void push_pkt(logic [7:0] s, bit rnd);
    push_byte(s);
    for (int i = 0; i < PKT_LEN - 1; i++) push_byte(rnd ? 8'($urandom) : 8'(i));
  endfunction

  // byte whose last (LSB) bit sits at stream index p; bits before 0 read as 0
  function automatic logic [7:0] byte_at(int p);
    logic [7:0] r = '0;
    for (int i = p - 7; i <= p; i++)
      r = {r[6:0], (i >= 0 && i < stream.size()) ? stream[i] : 1'b0};
    return r;
  endfunction

  function automatic void run_model();
    int n = stream.size();
    int pos = 0, p, q, miss, e, idx;
    bit ok;
    logic [7:0] b;
    model_locked = 0;
    model_lock_pos = -1;
    while (pos < n) begin
      p = pos;
      while (p < n && byte_at(p) != SYNC) p++;
      if (p >= n) break;
      ok = 1;
      q = p;
      for (int k = 1; k < SC; k++) begin
        q = p + k * PB;
        if (q >= n) begin ok = 0; pos = n; break; end
        if (byte_at(q) != SYNC) begin ok = 0; pos = q + 1; break; end
      end
      if (!ok) continue;
      model_locked = 1;
      if (model_lock_pos < 0) model_lock_pos = q;
      exp_q.push_back(ob_t'({SYNC, 3'b100}));
      miss = 0;
      pos = n;
      for (int j = 1; q + 8 * j < n; j++) begin
        e = q + 8 * j;
        idx = j % PKT_LEN;
        b = byte_at(e);
        if (idx == 0) begin
          if (b == SYNC) begin
            miss = 0;
            exp_q.push_back(ob_t'({b, 3'b100}));
          end else begin
            miss++;
            if (miss < LC) exp_q.push_back(ob_t'({b, 3'b101}));
            else begin model_locked = 0; pos = e + 1; break; end
          end
        end else begin
          exp_q.push_back(ob_t'({b, 1'b0, idx == PKT_LEN - 1, 1'b0}));
          if (idx == PKT_LEN - 1) model_pkts++;
        end
      end
    end
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    fifo_empty = 1'b1;
    fifo_q = 1'b0;
    out_ready = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_flags", {out_valid, out_sop, out_eop, out_err, locked}, 0);
    chk("rst_data", out_data, 0);
    chk("rst_pkts", pkt_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    stream.delete();
    model_pkts = 0;
  endtask

  // Plays stream[0:limit-1] through a show-ahead FIFO model; optional
  // 50-cycle READY-low window once stall_at bytes were accepted.
  task automatic feed(input int limit, input int gap_pct, input int rdy_pct, input int stall_at);
    int ptr = 0, cyc = 0, acc = 0, stall_left = 0;
    int budget = limit * 20 + 2000;
    bit cons, accd, hv = 0, stall_done = 0;
    logic [7:0] held = '0;
    ob_t e;
    while ((ptr < limit || out_valid) && cyc < budget) begin
      fifo_empty = (ptr >= limit) || ($urandom_range(99) < gap_pct);
      fifo_q = (ptr < limit) ? stream[ptr] : 1'b0;
      out_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      cons = fifo_rdreq;
      accd = out_valid & out_ready;
      if (accd) begin
        chk("avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("byte", {out_data, out_sop, out_eop, out_err}, e);
        end
      end
      if (stall_left > 0) begin
        if (out_valid) begin
          if (hv) chk("hold", out_data, held);
          else begin held = out_data; hv = 1; end
        end
        if (stall_left == 1) begin
          chk("stall_rdreq", fifo_rdreq, 0);
          chk("stall_pos", (ptr - model_lock_pos) % 8, 0);
        end
      end
      @(posedge clk); #1;
      if (cons) ptr++;
      if (accd) acc++;
      cyc++;
      if (stall_left > 0) stall_left--;
      else if (!stall_done && stall_at >= 0 && acc == stall_at) begin
        stall_left = 50;
        stall_done = 1;
      end
    end
    chk("timeout", cyc < budget, 1);
  endtask

  task automatic end_seg();
    chk("drain", exp_q.size(), 0);
    chk("pkt_cnt", pkt_count, model_pkts);
    chk("locked", locked, model_locked);
  endtask

  initial begin
    do_reset();

    // clean stream: lock on second sync, packets 2 and 3 out
    for (int i = 0; i < 3; i++) push_pkt(SYNC, 0);
    run_model();
    feed(stream.size(), 0, 100, -1);
    end_seg();
    chk("A_pkts", pkt_count, 2);
    chk("A_lock", locked, 1);

    // mid-packet start with garbage: false sync in payload must not lock
    do_reset();
    repeat (5) stream.push_back(bit'($urandom_range(1)));
    for (int i = 60; i < PKT_LEN - 1; i++) push_byte(8'(i));
    for (int i = 0; i < 4; i++) push_pkt(SYNC, 1);
    run_model();
    feed(stream.size(), 0, 100, -1);
    end_seg();

    // two flywheeled syncs then lock loss on the third
    do_reset();
    for (int i = 0; i < 3; i++) push_pkt(SYNC, 0);
    push_pkt(8'h46, 0);
    push_pkt(8'h46, 0);
    push_pkt(8'h46, 1);
    run_model();
    feed(stream.size(), 0, 100, -1);
    end_seg();
    chk("C_pkts", pkt_count, 4);
    chk("C_lock", locked, 0);

    // back-pressure mid-packet
    do_reset();
    for (int i = 0; i < 3; i++) push_pkt(SYNC, 1);
    run_model();
    feed(stream.size(), 0, 100, 300);
    end_seg();

    // FIFO gaps and random READY
    do_reset();
    for (int i = 0; i < 3; i++) push_pkt(SYNC, 0);
    run_model();
    feed(stream.size(), 30, 70, -1);
    end_seg();
    chk("E_pkts", pkt_count, 2);

    // reset in the middle of packet 2, then relock
    do_reset();
    for (int i = 0; i < 3; i++) push_pkt(SYNC, 0);
    run_model();
    feed(PB + 94 * 8 + 3, 0, 100, -1);
    do_reset();
    for (int i = 0; i < 3; i++) push_pkt(SYNC, 0);
    run_model();
    feed(stream.size(), 0, 100, -1);
    end_seg();
    chk("F_pkts", pkt_count, 2);
    chk("F_lock", locked, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
